// File: rtl/packet_router_pkg.sv
// Shared types and constants for the packet router/merger pair.
// The source-id header bit is common to tagging and routing.
package packet_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_S0,
    LOCK_S1
  } merger_state_t;

  localparam int SRC_ID_BIT = 0;

endpackage

// File: rtl/axis_skid_stage_sync.sv
// Two-entry AXI-Stream output register with synchronous active-low reset.
// Input ready is a register, so output ready never reaches the input combinationally.
module axis_skid_stage_sync #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] i_s_tdata,
  input  logic                   i_s_tlast,
  input  logic                   i_s_tvalid,
  output logic                   o_s_tready,
  output logic [TDATA_WIDTH-1:0] o_m_tdata,
  output logic                   o_m_tlast,
  output logic                   o_m_tvalid,
  input  logic                   i_m_tready
);

  logic [TDATA_WIDTH-1:0] r_out_data;
  logic                   r_out_last;
  logic                   r_out_vld;
  logic [TDATA_WIDTH-1:0] r_skid_data;
  logic                   r_skid_last;
  logic                   r_skid_vld;
  logic                   w_in_fire;
  logic                   w_load;

  assign o_s_tready = !r_skid_vld;
  assign w_in_fire  = i_s_tvalid && !r_skid_vld;
  assign w_load     = !r_out_vld || i_m_tready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_skid_vld  <= 1'b0;
    end else if (w_load) begin
      if (r_skid_vld) begin
        r_out_data <= r_skid_data;
        r_out_last <= r_skid_last;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_in_fire;
        if (w_in_fire) begin
          r_out_data <= i_s_tdata;
          r_out_last <= i_s_tlast;
        end
      end
    end else if (w_in_fire) begin
      // Output is stalled: park the beat accepted on the registered ready.
      r_skid_data <= i_s_tdata;
      r_skid_last <= i_s_tlast;
      r_skid_vld  <= 1'b1;
    end
  end

  assign o_m_tdata  = r_out_data;
  assign o_m_tlast  = r_out_last;
  assign o_m_tvalid = r_out_vld;

endmodule

// File: rtl/axis_packet_merger.sv
// Two-input AXI-Stream packet merger with packet-atomic round-robin.
// Optionally stamps the source index into the first beat of each packet.
module axis_packet_merger
  import packet_router_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter bit TAG_SOURCE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            num_packets_from_input_0,
  output logic [31:0]            num_packets_from_input_1
);

  merger_state_t          r_state;
  merger_state_t          w_state_nxt;
  logic                   r_last_grant;
  logic                   w_last_grant_nxt;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_out_ready;
  logic                   w_rdy;
  logic                   w_s0_fire;
  logic                   w_s1_fire;
  logic                   w_fire;
  logic                   w_last;
  logic [TDATA_WIDTH-1:0] w_data;
  logic [31:0]            r_cnt0;
  logic [31:0]            r_cnt1;

  assign w_rdy     = w_out_ready && resetn;
  assign w_s0_fire = w_gnt0 && w_rdy && s0_axis_tvalid;
  assign w_s1_fire = w_gnt1 && w_rdy && s1_axis_tvalid;
  assign w_fire    = w_s0_fire || w_s1_fire;

  assign s0_axis_tready = w_gnt0 && w_rdy;
  assign s1_axis_tready = w_gnt1 && w_rdy;

  always_comb begin
    w_gnt0           = 1'b0;
    w_gnt1           = 1'b0;
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          w_gnt0 = r_last_grant;
          w_gnt1 = !r_last_grant;
        end else begin
          w_gnt0 = s0_axis_tvalid;
          w_gnt1 = s1_axis_tvalid;
        end
      end
      LOCK_S0: w_gnt0 = 1'b1;
      LOCK_S1: w_gnt1 = 1'b1;
      default: ;
    endcase
    w_last = w_gnt1 ? s1_axis_tlast : s0_axis_tlast;
    w_data = w_gnt1 ? s1_axis_tdata : s0_axis_tdata;
    if (TAG_SOURCE && r_state == IDLE) begin
      w_data[SRC_ID_BIT] = w_gnt1;
    end
    if (w_fire) begin
      if (r_state == IDLE) begin
        w_last_grant_nxt = w_gnt1;
        if (!w_last) begin
          w_state_nxt = w_gnt1 ? LOCK_S1 : LOCK_S0;
        end
      end else if (w_last) begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Packets are counted when their last beat enters, not when it leaves.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_s0_fire && s0_axis_tlast) r_cnt0 <= r_cnt0 + 32'd1;
      if (w_s1_fire && s1_axis_tlast) r_cnt1 <= r_cnt1 + 32'd1;
    end
  end

  assign num_packets_from_input_0 = r_cnt0;
  assign num_packets_from_input_1 = r_cnt1;

  axis_skid_stage_sync #(
    .TDATA_WIDTH(TDATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .i_s_tdata (w_data),
    .i_s_tlast (w_last),
    .i_s_tvalid(w_fire),
    .o_s_tready(w_out_ready),
    .o_m_tdata (m_axis_tdata),
    .o_m_tlast (m_axis_tlast),
    .o_m_tvalid(m_axis_tvalid),
    .i_m_tready(m_axis_tready)
  );

endmodule

// File: tb/tb_axis_packet_merger.sv
// Directed bench for axis_packet_merger: arbitration, tagging,
// backpressure, fairness and reset behaviour.
module tb_axis_packet_merger;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s0_d, s1_d;
  logic        s0_l, s0_v, s1_l, s1_v;
  logic        s0_r, s1_r;
  logic [31:0] m_d;
  logic        m_l, m_v, m_r;
  logic [31:0] c0, c1;
  logic [31:0] r_m_d, rc0, rc1;
  logic        r_m_l, r_m_v, r_s0_r, r_s1_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [31:0] od[$];
  logic        ol[$];
  int          oc[$];
  logic [31:0] orw[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  logic        hv = 1'b0;
  logic [31:0] hd;
  logic        s1_seen;
  logic [31:0] base0;
  logic        bp_on;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_packet_merger #(.TDATA_WIDTH(32), .TAG_SOURCE(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .s0_axis_tdata(s0_d), .s0_axis_tlast(s0_l),
    .s0_axis_tvalid(s0_v), .s0_axis_tready(s0_r),
    .s1_axis_tdata(s1_d), .s1_axis_tlast(s1_l),
    .s1_axis_tvalid(s1_v), .s1_axis_tready(s1_r),
    .m_axis_tdata(m_d), .m_axis_tlast(m_l),
    .m_axis_tvalid(m_v), .m_axis_tready(m_r),
    .num_packets_from_input_0(c0),
    .num_packets_from_input_1(c1)
  );

  axis_packet_merger #(.TDATA_WIDTH(32), .TAG_SOURCE(1'b0)) u_raw (
    .clk(clk), .resetn(resetn),
    .s0_axis_tdata(s0_d), .s0_axis_tlast(s0_l),
    .s0_axis_tvalid(s0_v), .s0_axis_tready(r_s0_r),
    .s1_axis_tdata(s1_d), .s1_axis_tlast(s1_l),
    .s1_axis_tvalid(s1_v), .s1_axis_tready(r_s1_r),
    .m_axis_tdata(r_m_d), .m_axis_tlast(r_m_l),
    .m_axis_tvalid(r_m_v), .m_axis_tready(m_r),
    .num_packets_from_input_0(rc0),
    .num_packets_from_input_1(rc1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input int src, input logic v,
                     input logic [31:0] d, input logic l);
    if (src == 0) begin
      s0_v = v; s0_d = d; s0_l = l;
    end else begin
      s1_v = v; s1_d = d; s1_l = l;
    end
  endtask

  function automatic logic rdy(input int src);
    return (src == 0) ? s0_r : s1_r;
  endfunction

  task automatic add(input int src, input logic v,
                     input logic [31:0] d, input logic l);
    beat_t b;
    b = '{v: v, d: d, l: l};
    if (src == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Acceptance is judged 1ns before the rising edge, with inputs settled.
  task automatic drive(input int src);
    beat_t b;
    int n;
    forever begin
      if (src == 0 && q0.size() == 0) break;
      if (src == 1 && q1.size() == 0) break;
      if (src == 0) b = q0.pop_front();
      else b = q1.pop_front();
      @(negedge clk);
      put(src, b.v, b.d, b.l);
      if (b.v) begin
        n = 0;
        #4;
        while (!rdy(src) && n < 200) begin
          @(negedge clk);
          #4;
          n++;
        end
        if (n >= 200) check("drv_stuck", {31'b0, rdy(src)}, 32'd1);
        @(posedge clk);
      end
    end
    @(negedge clk);
    put(src, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (hv) check("stall_stable", m_d, hd);
      if (m_v && m_r) begin
        od.push_back(m_d);
        ol.push_back(m_l);
        oc.push_back(cyc);
        orw.push_back(r_m_d);
      end
      hv = m_v && !m_r;
      hd = m_d;
    end
  end

  task automatic clr();
    od.delete(); ol.delete(); oc.delete(); orw.delete();
  endtask

  task automatic wait_out(input string tag, input int n);
    int t;
    t = 0;
    while (od.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(tag, od.size(), n);
  endtask

  task automatic cmp_seq(input string tag);
    for (int i = 0; i < exp_d.size(); i++) begin
      check(tag, (i < od.size()) ? od[i] : 32'hDEAD_BEEF, exp_d[i]);
      check(tag, {31'b0, (i < ol.size()) ? ol[i] : 1'bx},
            {31'b0, exp_l[i]});
    end
  endtask

  initial begin
    resetn = 1'b0;
    m_r = 1'b1;
    bp_on = 1'b0;
    put(0, 1'b1, 32'hAAAA_AAAA, 1'b0);
    put(1, 1'b1, 32'h5555_5555, 1'b0);
    repeat (3) @(negedge clk);
    #4;
    check("rst_mvalid", {31'b0, m_v}, 32'd0);
    check("rst_mdata", m_d, 32'd0);
    check("rst_mlast", {31'b0, m_l}, 32'd0);
    check("rst_cnt0", c0, 32'd0);
    check("rst_cnt1", c1, 32'd0);
    check("rst_s0rdy", {31'b0, s0_r}, 32'd0);
    check("rst_s1rdy", {31'b0, s1_r}, 32'd0);
    check("rst_raw", {29'b0, r_s0_r, r_m_v, r_m_l}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    put(0, 1'b0, 32'h0, 1'b0);
    put(1, 1'b0, 32'h0, 1'b0);

    // Contention: S0 wins first, then S1
    clr();
    add(0, 1, 32'h10, 0); add(0, 1, 32'h11, 0); add(0, 1, 32'h12, 1);
    add(1, 1, 32'h21, 0); add(1, 1, 32'h22, 0); add(1, 1, 32'h23, 1);
    fork drive(0); drive(1); join
    wait_out("cont_n", 6);
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h21, 32'h22, 32'h23};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cmp_seq("cont");
    check("cont_cnt0", c0, 32'd1);
    check("cont_cnt1", c1, 32'd1);

    // Packet atomicity with a 2-cycle gap inside the S0 packet
    clr();
    add(0, 1, 32'h30, 0); add(0, 1, 32'h31, 0);
    add(0, 0, 32'h0, 0); add(0, 0, 32'h0, 0);
    add(0, 1, 32'h32, 0); add(0, 1, 32'h33, 1);
    add(1, 1, 32'h40, 0); add(1, 1, 32'h45, 1);
    s1_seen = 1'b0;
    base0 = c0;
    fork
      drive(0);
      drive(1);
      begin
        for (int t = 0; t < 100 && c0 == base0; t++) begin
          @(negedge clk);
          #4;
          if (c0 == base0) s1_seen = s1_seen | s1_r | r_s1_r;
        end
      end
    join
    wait_out("atom_n", 6);
    exp_d = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h41, 32'h45};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cmp_seq("atom");
    check("atom_s1rdy", {31'b0, s1_seen}, 32'd0);

    // Source tagging of first beats; untagged instance passes raw data
    clr();
    add(0, 1, 32'h0000_00FF, 0); add(0, 1, 32'h0000_0055, 1);
    add(1, 1, 32'h0000_0002, 0); add(1, 1, 32'h0000_0054, 1);
    fork drive(0); drive(1); join
    wait_out("tag_n", 4);
    exp_d = '{32'hFE, 32'h55, 32'h03, 32'h54};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    cmp_seq("tag");
    check("raw0", orw[0], 32'hFF);
    check("raw1", orw[1], 32'h55);
    check("raw2", orw[2], 32'h02);
    check("raw3", orw[3], 32'h54);

    // Backpressure on a 16-beat S1 packet
    clr();
    exp_d.delete(); exp_l.delete();
    for (int i = 0; i < 16; i++) begin
      add(1, 1, 32'h201 + i, i == 15);
      exp_d.push_back(32'h201 + i);
      exp_l.push_back(i == 15);
    end
    bp_on = 1'b1;
    fork
      begin
        drive(1);
        wait_out("bp_n", 16);
        bp_on = 1'b0;
      end
      begin
        for (int k = 0; k < 2000 && bp_on; k++) begin
          @(negedge clk);
          m_r = (k % 3 == 0);
        end
      end
    join
    @(negedge clk);
    m_r = 1'b1;
    cmp_seq("bp");

    // Fairness with single-beat packets after a fresh reset
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    clr();
    exp_d.delete(); exp_l.delete();
    for (int i = 0; i < 8; i++) begin
      add(0, 1, 32'h300 + 2 * i, 1);
      add(1, 1, 32'h401 + 2 * i, 1);
      exp_d.push_back(32'h300 + 2 * i);
      exp_d.push_back(32'h401 + 2 * i);
      exp_l.push_back(1'b1);
      exp_l.push_back(1'b1);
    end
    fork drive(0); drive(1); join
    wait_out("fair_n", 16);
    cmp_seq("fair");
    check("fair_tput", oc[15] - oc[0], 32'd15);
    check("fair_cnt0", c0, 32'd8);
    check("fair_cnt1", c1, 32'd8);
    check("fair_rcnt", {rc0[15:0], rc1[15:0]}, {16'd8, 16'd8});

    // Reset during beat 3 of an S0 packet
    @(negedge clk);
    put(0, 1, 32'h50, 0);
    @(negedge clk);
    put(0, 1, 32'h52, 0);
    @(negedge clk);
    put(0, 1, 32'h54, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    put(0, 0, 32'h0, 0);
    clr();
    #4;
    check("mid_mvalid", {31'b0, m_v}, 32'd0);
    check("mid_cnt0", c0, 32'd0);
    check("mid_cnt1", c1, 32'd0);
    add(1, 1, 32'h61, 0); add(1, 1, 32'h63, 1);
    drive(1);
    wait_out("mid_n", 2);
    exp_d = '{32'h61, 32'h63};
    exp_l = '{1'b0, 1'b1};
    cmp_seq("mid");
    check("mid_cnt1b", c1, 32'd1);
    check("mid_cnt0b", c0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
